// File: rtl/monitor_peatonal_if.sv
// Pedestrian-monitor bus: sequencer lights and tick in, pedestrian lamps,
// countdown and fault flag out.
interface monitor_peatonal_if #(
  parameter int unsigned CNT_W = 6
);
  logic             tick;
  logic             rojo;
  logic             amarillo;
  logic             verde;
  logic             clr_falla;
  logic             peaton_verde;
  logic             peaton_rojo;
  logic [CNT_W-1:0] cuenta;
  logic             falla;

  // Upstream side (sequencer / controller): drives lights, tick and clear.
  modport master (
    output tick, rojo, amarillo, verde, clr_falla,
    input  peaton_verde, peaton_rojo, cuenta, falla
  );

  // Pedestrian monitor side.
  modport slave (
    input  tick, rojo, amarillo, verde, clr_falla,
    output peaton_verde, peaton_rojo, cuenta, falla
  );
endinterface

// File: rtl/monitor_peatonal.sv
// Pedestrian signal stage: follows the vehicle light sequence, drives the
// walk/don't-walk lamps with a crossing countdown and a flashing tail, and
// latches a sticky fault on illegal light patterns or transitions.
module monitor_peatonal #(
  parameter int unsigned ROJO_TICS     = 35,
  parameter int unsigned DESTELLO_TICS = 5,
  parameter int unsigned CNT_W         = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  monitor_peatonal_if.slave bus
);

  typedef enum logic [1:0] {
    ESPERA,
    CRUCE,
    DESTELLO,
    FALLA
  } estado_t;

  // Light patterns as {rojo, amarillo, verde}
  localparam logic [2:0] L_VERDE = 3'b001;
  localparam logic [2:0] L_AMAR  = 3'b010;
  localparam logic [2:0] L_ROJO  = 3'b100;

  localparam logic [CNT_W-1:0] CARGA  = CNT_W'(ROJO_TICS);
  localparam logic [CNT_W-1:0] UMBRAL = CNT_W'(DESTELLO_TICS);
  // Flash window covers the whole red: skip the walk phase entirely.
  localparam bit DESTELLO_INMEDIATO = (DESTELLO_TICS >= ROJO_TICS);

  estado_t          estado_q, estado_d;
  logic             sync_q, sync_d;
  logic [2:0]       prev_q;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic             pv_q, pv_d;
  logic             pr_q, pr_d;
  logic             falla_q, falla_d;

  logic [2:0]       luces;
  logic             legal, prev_legal, paso_ok, violacion, entrada, salida;
  logic [CNT_W-1:0] dec;

  // Pattern/transition classification and saturating decrement
  always_comb begin
    luces      = {bus.rojo, bus.amarillo, bus.verde};
    legal      = (luces == L_VERDE) || (luces == L_AMAR) || (luces == L_ROJO);
    prev_legal = (prev_q == L_VERDE) || (prev_q == L_AMAR) || (prev_q == L_ROJO);
    paso_ok    = ((prev_q == L_VERDE) && (luces == L_AMAR)) ||
                 ((prev_q == L_AMAR)  && (luces == L_ROJO)) ||
                 ((prev_q == L_ROJO)  && (luces == L_VERDE));
    // An illegal previous pattern was already flagged; only legal->legal
    // changes are judged as transitions.
    violacion  = sync_q && (!legal || (prev_legal && (luces != prev_q) && !paso_ok));
    entrada    = sync_q && (prev_q == L_AMAR) && (luces == L_ROJO);
    salida     = (prev_q == L_ROJO) && (luces == L_VERDE);
    dec        = (cuenta_q == '0) ? '0 : cuenta_q - 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    estado_d = estado_q;
    sync_d   = sync_q;
    cuenta_d = cuenta_q;
    pv_d     = pv_q;
    pr_d     = pr_q;
    falla_d  = falla_q;

    if (estado_q == FALLA) begin
      // A fresh violation on the clear edge keeps the fault latched.
      if (!violacion && bus.clr_falla) begin
        estado_d = ESPERA;
        sync_d   = 1'b0;
        falla_d  = 1'b0;
      end
    end else if (violacion) begin
      estado_d = FALLA;
      falla_d  = 1'b1;
      pv_d     = 1'b0;
      pr_d     = 1'b1;
      cuenta_d = '0;
    end else if (!sync_q) begin
      if (legal) begin
        sync_d = 1'b1;
      end
    end else if (estado_q == ESPERA) begin
      if (entrada) begin
        cuenta_d = CARGA;
        if (DESTELLO_INMEDIATO) begin
          estado_d = DESTELLO;
          pv_d     = 1'b0;
          pr_d     = 1'b1;
        end else begin
          estado_d = CRUCE;
          pv_d     = 1'b1;
          pr_d     = 1'b0;
        end
      end
    end else if (salida) begin
      estado_d = ESPERA;
      cuenta_d = '0;
      pv_d     = 1'b0;
      pr_d     = 1'b1;
    end else if (bus.tick) begin
      cuenta_d = dec;
      if (estado_q == CRUCE) begin
        if (dec == UMBRAL) begin
          estado_d = DESTELLO;
          pv_d     = 1'b0;
          pr_d     = 1'b1;
        end
      end else begin
        pr_d = ~pr_q;
      end
    end
  end

  // State, sync flag, previous lights and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= ESPERA;
      sync_q   <= 1'b0;
      prev_q   <= 3'b000;
      cuenta_q <= '0;
      pv_q     <= 1'b0;
      pr_q     <= 1'b1;
      falla_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sync_q   <= sync_d;
      prev_q   <= luces;
      cuenta_q <= cuenta_d;
      pv_q     <= pv_d;
      pr_q     <= pr_d;
      falla_q  <= falla_d;
    end
  end

  assign bus.peaton_verde = pv_q;
  assign bus.peaton_rojo  = pr_q;
  assign bus.cuenta       = cuenta_q;
  assign bus.falla        = falla_q;

endmodule

// File: tb/tb_monitor_peatonal.sv
// Bench for monitor_peatonal: directed vector table, hand sequences for
// reset mid-flash, and randomized light streams against a reference model.
module tb_monitor_peatonal;

  localparam int ROJO = 8;
  localparam int DEST = 3;
  localparam int W    = 6;

  localparam logic [2:0] V  = 3'b001;
  localparam logic [2:0] A  = 3'b010;
  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] RV = 3'b101;
  localparam logic [2:0] NO = 3'b000;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  monitor_peatonal_if #(.CNT_W(W)) bus ();

  monitor_peatonal #(
    .ROJO_TICS    (ROJO),
    .DESTELLO_TICS(DEST),
    .CNT_W        (W)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         t;
    logic [2:0] l;
    bit         c;
    bit         pv;
    bit         pr;
    int         cnt;
    bit         f;
  } vec_t;

  vec_t tabla[$];

  function automatic vec_t mk(bit t, logic [2:0] l, bit c, bit pv, bit pr, int cnt, bit f);
    vec_t v;
    v.t = t; v.l = l; v.c = c; v.pv = pv; v.pr = pr; v.cnt = cnt; v.f = f;
    return v;
  endfunction

  // Reference model: crossing tracked as ticks elapsed since red began.
  bit         m_fault, m_sync, m_cross;
  logic [2:0] m_prev;
  int         m_ticks;

  function automatic logic [2:0] siguiente(logic [2:0] p);
    case (p)
      V:       return A;
      A:       return R;
      R:       return V;
      default: return NO;
    endcase
  endfunction

  task automatic model_reset();
    m_fault = 0; m_sync = 0; m_cross = 0; m_prev = NO; m_ticks = 0;
  endtask

  task automatic model_step(input bit t, input logic [2:0] l, input bit c);
    bit legal, bad;
    legal = ($countones(l) == 1);
    bad = m_sync && (!legal || (($countones(m_prev) == 1) && (l != m_prev) && (siguiente(m_prev) != l)));
    if (m_fault) begin
      if (!bad && c) begin m_fault = 0; m_sync = 0; end
    end else if (bad) begin
      m_fault = 1; m_cross = 0;
    end else if (!m_sync) begin
      if (legal) m_sync = 1;
    end else if (m_cross && m_prev == R && l == V) begin
      m_cross = 0;
    end else if (!m_cross && m_prev == A && l == R) begin
      m_cross = 1; m_ticks = 0;
    end else if (m_cross && t) begin
      m_ticks++;
    end
    m_prev = l;
  endtask

  task automatic model_expect(output bit pv, output bit pr, output int cnt, output bit f);
    int walk_end;
    pv = 0; pr = 1; cnt = 0; f = m_fault;
    if (!m_fault && m_cross) begin
      cnt      = (m_ticks >= ROJO) ? 0 : ROJO - m_ticks;
      walk_end = (ROJO > DEST) ? ROJO - DEST : 0;
      if (m_ticks < walk_end) begin
        pv = 1; pr = 0;
      end else begin
        pv = 0; pr = (((m_ticks - walk_end) % 2) == 0);
      end
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit pv, input bit pr, input int cnt, input bit f);
    check({tag, ".peaton_verde"}, int'(bus.peaton_verde), int'(pv));
    check({tag, ".peaton_rojo"},  int'(bus.peaton_rojo),  int'(pr));
    check({tag, ".cuenta"},       int'(bus.cuenta),       cnt);
    check({tag, ".falla"},        int'(bus.falla),        int'(f));
  endtask

  task automatic ciclo(input bit t, input logic [2:0] l, input bit c);
    bus.tick = t;
    {bus.rojo, bus.amarillo, bus.verde} = l;
    bus.clr_falla = c;
    @(posedge clock);
    #1;
    if (reset_n) model_step(t, l, c);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.tick = 0; bus.rojo = 0; bus.amarillo = 0; bus.verde = 0; bus.clr_falla = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset", 0, 1, 0, 0);
    reset_n = 1'b1;
  endtask

  bit         e_pv, e_pr, e_f;
  int         e_cnt;
  logic [2:0] fase, luz;
  bit         rt, rc;

  initial begin
    do_reset();

    // Normal cycle, saturation, early exit, faults and clears
    tabla.push_back(mk(0, V,  0, 0, 1, 0, 0));
    tabla.push_back(mk(0, A,  0, 0, 1, 0, 0));
    tabla.push_back(mk(1, R,  0, 1, 0, 8, 0));  // tick on entry ignored
    tabla.push_back(mk(1, R,  0, 1, 0, 7, 0));
    tabla.push_back(mk(0, R,  0, 1, 0, 7, 0));
    tabla.push_back(mk(1, R,  0, 1, 0, 6, 0));
    tabla.push_back(mk(1, R,  0, 1, 0, 5, 0));
    tabla.push_back(mk(1, R,  0, 1, 0, 4, 0));
    tabla.push_back(mk(1, R,  0, 0, 1, 3, 0));  // flashing begins
    tabla.push_back(mk(1, R,  0, 0, 0, 2, 0));
    tabla.push_back(mk(1, R,  0, 0, 1, 1, 0));
    tabla.push_back(mk(1, R,  0, 0, 0, 0, 0));
    tabla.push_back(mk(1, R,  0, 0, 1, 0, 0));  // saturated, still toggling
    tabla.push_back(mk(1, R,  0, 0, 0, 0, 0));
    tabla.push_back(mk(1, V,  0, 0, 1, 0, 0));  // exit wins over tick
    tabla.push_back(mk(0, A,  0, 0, 1, 0, 0));
    tabla.push_back(mk(0, R,  0, 1, 0, 8, 0));
    tabla.push_back(mk(1, R,  0, 1, 0, 7, 0));
    tabla.push_back(mk(1, R,  0, 1, 0, 6, 0));
    tabla.push_back(mk(0, V,  0, 0, 1, 0, 0));  // early exit
    tabla.push_back(mk(1, R,  0, 0, 1, 0, 1));  // verde->rojo illegal
    tabla.push_back(mk(0, RV, 1, 0, 1, 0, 1));  // clear loses to new violation
    tabla.push_back(mk(0, V,  0, 0, 1, 0, 1));
    tabla.push_back(mk(0, A,  1, 0, 1, 0, 0));  // clear
    tabla.push_back(mk(0, A,  0, 0, 1, 0, 0));  // resync
    tabla.push_back(mk(0, R,  0, 1, 0, 8, 0));  // crossing after clear
    tabla.push_back(mk(1, RV, 0, 0, 1, 0, 1));  // two lamps mid-crossing
    tabla.push_back(mk(0, R,  0, 0, 1, 0, 1));
    tabla.push_back(mk(1, R,  1, 0, 1, 0, 0));
    tabla.push_back(mk(0, V,  0, 0, 1, 0, 0));
    tabla.push_back(mk(0, A,  0, 0, 1, 0, 0));
    tabla.push_back(mk(0, R,  0, 1, 0, 8, 0));
    tabla.push_back(mk(0, NO, 0, 0, 1, 0, 1));  // all dark
    tabla.push_back(mk(0, R,  1, 0, 1, 0, 0));
    tabla.push_back(mk(1, R,  0, 0, 1, 0, 0));  // red on resync: no crossing

    for (int i = 0; i < tabla.size(); i++) begin
      ciclo(tabla[i].t, tabla[i].l, tabla[i].c);
      check_outs($sformatf("vec%0d", i), tabla[i].pv, tabla[i].pr, tabla[i].cnt, tabla[i].f);
    end

    // Reset asserted mid-flash with cuenta=3
    do_reset();
    ciclo(0, V, 0);
    ciclo(0, A, 0);
    ciclo(0, R, 0);
    repeat (5) ciclo(1, R, 0);
    check_outs("pre_reset", 0, 1, 3, 0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outs("async_reset", 0, 1, 0, 0);
    ciclo(1, R, 0);
    check_outs("held_reset", 0, 1, 0, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ciclo(1, R, 0);
      check_outs($sformatf("red_after_reset%0d", i), 0, 1, 0, 0);
    end
    ciclo(0, V, 0);
    ciclo(0, A, 0);
    ciclo(1, R, 0);
    check_outs("cross_after_reset", 1, 0, 8, 0);

    // Randomized light streams against the reference model
    do_reset();
    fase = V;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 1) begin
        luz = 3'($urandom_range(0, 7));
      end else begin
        if ($urandom_range(0, (fase == R) ? 19 : 3) == 0) fase = siguiente(fase);
        luz = fase;
      end
      rt = ($urandom_range(0, 1) == 1);
      rc = ($urandom_range(0, 24) == 0);
      ciclo(rt, luz, rc);
      model_expect(e_pv, e_pr, e_cnt, e_f);
      check_outs($sformatf("rnd%0d", i), e_pv, e_pr, e_cnt, e_f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
